multiplier_output_pipeline: RTL and testbench

//  Parametrised multiplier output register stage for the PIRDSP slice: 0..MAX_STAGES register levels

---
 rtl/multiplier_output_pipeline_if.sv | 30 +++
 rtl/multiplier_output_pipeline.sv | 119 +++++++++++
 tb/tb_multiplier_output_pipeline.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_output_pipeline_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : multiplier_output_pipeline_if                                    |
// | Brief   : Data/control bundle between multiplier, output pipeline and ALU. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface multiplier_output_pipeline_if #(
  parameter int M_WIDTH    = 90,
  parameter int SIMD_WIDTH = 16
);
  logic [M_WIDTH-1:0]    M_temp;
  logic [SIMD_WIDTH-1:0] result_SIMD_carry;
  logic                  in_valid;
  logic                  RSTM;
  logic                  CEM;
  logic [M_WIDTH-1:0]    M;
  logic [SIMD_WIDTH-1:0] M_SIMD;
  logic                  out_valid;

  modport master (
    output M_temp, result_SIMD_carry, in_valid, RSTM, CEM,
    input  M, M_SIMD, out_valid
  );

  modport slave (
    input  M_temp, result_SIMD_carry, in_valid, RSTM, CEM,
    output M, M_SIMD, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/multiplier_output_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : multiplier_output_pipeline                                       |
// | Brief   : 0..MAX_STAGES scan-configured register levels after multiplier.  |
// |           Optional MOP_HOLD_CNT_EN adds a stall counter output hold_cnt.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multiplier_output_pipeline #(
  parameter int M_WIDTH    = 90,
  parameter int SIMD_WIDTH = 16,
  parameter int MAX_STAGES = 2,
  parameter int DEPTH_BITS = 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  multiplier_output_pipeline_if.slave bus,
  input  wire logic                   configuration_input,
  input  wire logic                   configuration_enable,
  output logic                        configuration_output
`ifdef MOP_HOLD_CNT_EN
  ,
  output logic [7:0]                  hold_cnt
`endif
);

  localparam int                    c_cfg_w     = DEPTH_BITS + 2;
  localparam logic [DEPTH_BITS-1:0] c_max_depth = DEPTH_BITS'(MAX_STAGES);

  logic [c_cfg_w-1:0]    r_cfg;
  logic [DEPTH_BITS-1:0] w_mdepth;
  logic [DEPTH_BITS-1:0] w_depth;
  logic                  w_rst;
  logic                  w_ce;

  logic [M_WIDTH-1:0]    r_data  [1:MAX_STAGES];
  logic [SIMD_WIDTH-1:0] r_simd  [1:MAX_STAGES];
  logic                  r_valid [1:MAX_STAGES];

  logic [M_WIDTH-1:0]    w_m;
  logic [SIMD_WIDTH-1:0] w_m_simd;
  logic                  w_out_valid;

  // Scan chain: first bit shifted in ends up in the MSB (depth field).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg <= '0;
    end else if (configuration_enable) begin
      r_cfg <= {r_cfg[c_cfg_w-2:0], configuration_input};
    end
  end

  assign configuration_output = r_cfg[c_cfg_w-1];
  assign w_mdepth = r_cfg[c_cfg_w-1:2];
  assign w_rst    = bus.RSTM ^ r_cfg[0];
  assign w_ce     = bus.CEM  ^ r_cfg[1];
  assign w_depth  = (w_mdepth > c_max_depth) ? c_max_depth : w_mdepth;

  // Every stage shifts on ce regardless of the selected depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= MAX_STAGES; k++) begin
        r_data[k]  <= '0;
        r_simd[k]  <= '0;
        r_valid[k] <= 1'b0;
      end
    end else if (w_rst) begin
      for (int k = 1; k <= MAX_STAGES; k++) begin
        r_data[k]  <= '0;
        r_simd[k]  <= '0;
        r_valid[k] <= 1'b0;
      end
    end else if (w_ce) begin
      r_data[1]  <= bus.M_temp;
      r_simd[1]  <= bus.result_SIMD_carry;
      r_valid[1] <= bus.in_valid;
      for (int k = 2; k <= MAX_STAGES; k++) begin
        r_data[k]  <= r_data[k-1];
        r_simd[k]  <= r_simd[k-1];
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  always_comb begin
    w_m         = bus.M_temp;
    w_m_simd    = bus.result_SIMD_carry;
    w_out_valid = bus.in_valid;
    for (int k = 1; k <= MAX_STAGES; k++) begin
      if (w_depth == DEPTH_BITS'(k)) begin
        w_m         = r_data[k];
        w_m_simd    = r_simd[k];
        w_out_valid = r_valid[k];
      end
    end
  end

  assign bus.M         = w_m;
  assign bus.M_SIMD    = w_m_simd;
  assign bus.out_valid = w_out_valid;

`ifdef MOP_HOLD_CNT_EN
  logic [7:0] r_hold_cnt;

  // Counts edges on which a valid registered result is being stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= 8'd0;
    end else if (w_rst || w_ce) begin
      r_hold_cnt <= 8'd0;
    end else if (w_out_valid && (w_depth != '0) && (r_hold_cnt != 8'hFF)) begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  assign hold_cnt = r_hold_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multiplier_output_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_multiplier_output_pipeline                                    |
// | Brief   : Directed scoreboard bench for multiplier_output_pipeline.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multiplier_output_pipeline;

  typedef struct packed {
    logic [89:0] data;
    logic [15:0] simd;
    logic        valid;
  } vec_t;

  logic clk;
  logic rst_n;
  logic cfg_in;
  logic cfg_en;
  logic cfg_out;
`ifdef MOP_HOLD_CNT_EN
  logic [7:0] hold_cnt;
`endif

  int   errors = 0;
  int   checks = 0;
  logic tb_rstm_inv = 1'b0;
  logic tb_cem_inv  = 1'b0;
  vec_t q[$];

  multiplier_output_pipeline_if #(.M_WIDTH(90), .SIMD_WIDTH(16)) bus ();

  multiplier_output_pipeline #(
    .M_WIDTH(90), .SIMD_WIDTH(16), .MAX_STAGES(2), .DEPTH_BITS(2)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bus                  (bus.slave),
    .configuration_input  (cfg_in),
    .configuration_enable (cfg_en),
    .configuration_output (cfg_out)
`ifdef MOP_HOLD_CNT_EN
    ,
    .hold_cnt             (hold_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t rand_vec(input logic valid);
    logic [95:0] r96;
    vec_t        v;
    r96     = {$urandom(), $urandom(), $urandom()};
    v.data  = r96[89:0];
    v.simd  = 16'($urandom());
    v.valid = valid;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.M_temp            = v.data;
    bus.result_SIMD_carry = v.simd;
    bus.in_valid          = v.valid;
  endtask

  task automatic check_out(input string tag, input vec_t e);
    check({tag, "_data"},  128'(bus.M),         128'(e.data));
    check({tag, "_simd"},  128'(bus.M_SIMD),    128'(e.simd));
    check({tag, "_valid"}, 128'(bus.out_valid), 128'(e.valid));
  endtask

  // Bits are sent MSB first so the word lands in cfg exactly as written.
  task automatic shift_cfg(input logic [3:0] bits);
    for (int j = 0; j < 4; j++) begin
      cfg_en = 1'b1;
      cfg_in = bits[3-j];
      tick();
    end
    cfg_en      = 1'b0;
    tb_rstm_inv = bits[0];
    tb_cem_inv  = bits[1];
    bus.RSTM    = tb_rstm_inv;
    bus.CEM     = ~tb_cem_inv;
  endtask

  task automatic stream(input string tag, input int n, input int d);
    vec_t e;
    vec_t z;
    z = '0;
    q.delete();
    bus.CEM  = ~tb_cem_inv;
    bus.RSTM = ~tb_rstm_inv;
    tick();
    bus.RSTM = tb_rstm_inv;
    for (int i = 0; i < n + d; i++) begin
      e = (i < n) ? rand_vec(1'b1) : z;
      drive(e);
      q.push_back(e);
      tick();
      if (q.size() == d) begin
        e = q.pop_front();
        check_out(tag, e);
      end else begin
        check({tag, "_fill_valid"}, 128'(bus.out_valid), 128'(0));
      end
    end
  endtask

  task automatic fill_then_clear(input string tag);
    vec_t v;
    vec_t z;
    z = '0;
    v = rand_vec(1'b1);
    bus.CEM = ~tb_cem_inv;
    drive(v);
    tick();
    tick();
    check_out({tag, "_fill"}, v);
    drive(rand_vec(1'b1));
    bus.RSTM = ~tb_rstm_inv;
    tick();
    check_out({tag, "_clr"}, z);
    bus.RSTM = tb_rstm_inv;
  endtask

  initial begin
    vec_t        h;
    vec_t        v;
    logic [3:0]  p;
    logic [3:0]  nq;

    // Reset: depth 0 bypass with non-inverted controls
    rst_n    = 1'b0;
    cfg_in   = 1'b0;
    cfg_en   = 1'b0;
    bus.RSTM = 1'b0;
    bus.CEM  = 1'b1;
    v.data = 90'h1; v.simd = 16'h00A5; v.valid = 1'b1;
    drive(v);
    @(negedge clk);
    @(negedge clk);
    check_out("reset", v);
    check("reset_cfg_out", 128'(cfg_out), 128'(0));
`ifdef MOP_HOLD_CNT_EN
    check("reset_hold_cnt", 128'(hold_cnt), 128'(0));
`endif
    rst_n = 1'b1;
    tick();

    // Depth 2, ce always on
    shift_cfg(4'b1000);
    stream("d2", 4, 2);

    // Depth 1 with a three-edge stall
    shift_cfg(4'b0100);
    h = rand_vec(1'b1);
    drive(h);
    tick();
    check_out("d1_load", h);
    bus.CEM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(rand_vec(1'b1));
      tick();
      check_out("d1_hold", h);
    end
`ifdef MOP_HOLD_CNT_EN
    check("hold_cnt3", 128'(hold_cnt), 128'(3));
`endif
    v = rand_vec(1'b1);
    drive(v);
    bus.CEM = 1'b1;
    tick();
    check_out("d1_resume", v);
`ifdef MOP_HOLD_CNT_EN
    check("hold_cnt_clr", 128'(hold_cnt), 128'(0));
`endif

    // Inverted RSTM: RSTM=0 clears at depth 2
    shift_cfg(4'b1001);
    fill_then_clear("rstm_inv");

    // MDEPTH=3 saturates to 2; clear beats ce
    shift_cfg(4'b1100);
    stream("d3", 3, 2);
    fill_then_clear("clr_wins");

    // Inverted CEM: CEM=0 enables shifting
    shift_cfg(4'b1110);
    stream("cem_inv", 3, 2);

    // Scan-out replays the previously shifted word in order
    p  = 4'b1011;
    nq = 4'b0110;
    shift_cfg(p);
    for (int j = 0; j < 4; j++) begin
      cfg_en = 1'b1;
      cfg_in = nq[3-j];
      check("cfg_replay", 128'(cfg_out), 128'(p[3-j]));
      tick();
    end
    cfg_en = 1'b0;

    // Back to depth 0: combinational bypass
    shift_cfg(4'b0000);
    v = rand_vec(1'b1);
    drive(v);
    #1;
    check_out("bypass_v", v);
    v = rand_vec(1'b0);
    drive(v);
    #1;
    check_out("bypass_nv", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
